// File: rtl/sync_readback_if.sv
`timescale 1ns/10ps
// sync_readback_if: bundles the signals of the cross-clock read port.
//   Source side: sREQ (request), sRDY (idle), sVALID (result pulse), sD_OUT (result).
//   Destination side: dD_IN (value to sample), dPULSE (capture strobe).
// master = requester/owner of dD_IN, slave = the synchronizer block.
interface sync_readback_if #(
  parameter int width = 32
);
  logic             sREQ;
  logic             sRDY;
  logic             sVALID;
  logic [width-1:0] sD_OUT;
  logic [width-1:0] dD_IN;
  logic             dPULSE;

  modport master (
    output sREQ,
    output dD_IN,
    input  sRDY,
    input  sVALID,
    input  sD_OUT,
    input  dPULSE
  );

  modport slave (
    input  sREQ,
    input  dD_IN,
    output sRDY,
    output sVALID,
    output sD_OUT,
    output dPULSE
  );
endinterface

// File: rtl/sync_readback.sv
`timescale 1ns/10ps
// sync_readback: samples a dCLK-domain value on request from the sCLK domain and
//   returns it through a toggle request/acknowledge handshake.
// Latency: accept -> sVALID is 2-3 dCLK + 3-4 sCLK; one transaction in flight.
// Backpressure: sRDY low while a read is outstanding; sREQ is ignored (not queued) then.
// Ports:
//   sCLK, sRST   source clock, synchronous active-high reset (also resets dCLK side)
//   dCLK         destination clock
//   io.sREQ/sRDY/sVALID/sD_OUT   source-domain request, idle, result pulse, result
//   io.dD_IN/dPULSE              destination value, one-dCLK capture strobe
module sync_readback #(
  parameter int               width = 32,
  parameter logic [width-1:0] init  = {width{1'b0}}
) (
  input  logic           sCLK,
  input  logic           sRST,
  input  logic           dCLK,
  sync_readback_if.slave io
);

  // ---------------- source domain ----------------
  logic             r_sReqT;
  logic             r_sAckS1;
  logic             r_sAckS2;
  logic             r_sAckL;
  logic             r_sPend;
  logic             r_sVALID;
  logic [width-1:0] r_sD_OUT;

  // ---------------- destination domain ----------------
  logic             r_dRstS1;
  logic             r_dRst;
  logic             r_dReqS1;
  logic             r_dReqS2;
  logic             r_dAckT;
  logic             r_dPULSE;
  logic [width-1:0] r_dHold;

  logic w_sRDY;
  logic w_accept;
  logic w_done;

  // Idle only when nothing is pending and the returned ack matches our request
  // toggle; after reset this holds sRDY low until a stale ack has been cleared
  // and that clear has travelled back through the synchronizer.
  assign w_sRDY   = ~sRST & ~r_sPend & (r_sAckS2 == r_sReqT);
  assign w_accept = io.sREQ & w_sRDY;
  // Completion needs an ack edge that lands on our current toggle; an ack edge
  // with nothing pending (left over from a reset) is simply absorbed.
  assign w_done   = r_sPend & (r_sAckS2 != r_sAckL) & (r_sAckS2 == r_sReqT);

  always_ff @(posedge sCLK) begin
    if (sRST) begin
      r_sReqT  <= 1'b0;
      r_sAckS1 <= 1'b0;
      r_sAckS2 <= 1'b0;
      r_sAckL  <= 1'b0;
      r_sPend  <= 1'b0;
      r_sVALID <= 1'b0;
      r_sD_OUT <= init;
    end else begin
      r_sAckS1 <= r_dAckT;
      r_sAckS2 <= r_sAckS1;
      r_sAckL  <= r_sAckS2;
      r_sVALID <= 1'b0;
      if (w_accept) begin
        r_sReqT <= ~r_sReqT;
        r_sPend <= 1'b1;
      end
      if (w_done) begin
        // r_dHold has been stable for at least two sCLK by now and stays so
        // until the next request: a quasi-static crossing (false path).
        r_sD_OUT <= r_dHold;
        r_sVALID <= 1'b1;
        r_sPend  <= 1'b0;
      end
    end
  end

  // Reset synchronizer into dCLK; the synchronizer flops themselves are not reset.
  always_ff @(posedge dCLK) begin
    r_dRstS1 <= sRST;
    r_dRst   <= r_dRstS1;
  end

  always_ff @(posedge dCLK) begin
    if (r_dRst) begin
      r_dReqS1 <= 1'b0;
      r_dReqS2 <= 1'b0;
      r_dAckT  <= 1'b0;
      r_dPULSE <= 1'b0;
      r_dHold  <= init;
    end else begin
      r_dReqS1 <= r_sReqT;
      r_dReqS2 <= r_dReqS1;
      r_dPULSE <= 1'b0;
      if (r_dReqS2 != r_dAckT) begin
        // Capture and acknowledge on the same edge; dHold changes only here.
        r_dHold  <= io.dD_IN;
        r_dAckT  <= r_dReqS2;
        r_dPULSE <= 1'b1;
      end
    end
  end

  assign io.sRDY   = w_sRDY;
  assign io.sVALID = r_sVALID;
  assign io.sD_OUT = r_sD_OUT;
  assign io.dPULSE = r_dPULSE;

endmodule

// File: tb/tb_sync_readback.sv
`timescale 1ns/10ps
module tb_sync_readback;

  localparam logic [31:0] INIT = 32'h0;

  logic    sCLK = 1'b0;
  logic    dCLK = 1'b0;
  logic    sRST = 1'b1;
  realtime s_half = 5.0;
  realtime d_half = 6.5;

  always #(s_half) sCLK = ~sCLK;
  always #(d_half) dCLK = ~dCLK;

  sync_readback_if #(.width(32)) io ();
  sync_readback_if #(.width(1))  io1 ();

  sync_readback #(.width(32), .init(INIT)) dut (
    .sCLK(sCLK), .sRST(sRST), .dCLK(dCLK), .io(io)
  );
  sync_readback #(.width(1), .init(1'b1)) dut1 (
    .sCLK(sCLK), .sRST(sRST), .dCLK(dCLK), .io(io1)
  );

  int          tests = 0;
  int          fails = 0;
  int          accepts = 0;
  int          pulses = 0;
  int          valids = 0;
  bit          outstanding = 1'b0;
  bit          in_rst = 1'b1;
  bit          cnt_chk = 1'b0;
  bit          have_last = 1'b0;
  logic [31:0] last_sd;
  logic [31:0] mon_exp;
  logic [31:0] exp_q[$];
  int          dmode = 0;
  logic [31:0] d_fixed = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Destination data source: fixed, free-running counter, or random; changes
  // on the falling dCLK edge so it is stable around every capture edge.
  always @(negedge dCLK) begin
    case (dmode)
      1:       io.dD_IN = io.dD_IN + 32'd1;
      2:       io.dD_IN = $urandom;
      default: io.dD_IN = d_fixed;
    endcase
  end

  // Reference model, destination side: every capture strobe records the value
  // present at that edge as the next expected result.
  always begin
    @(posedge dCLK);
    #0.1;
    if (!in_rst && io.dPULSE === 1'b1) begin
      pulses++;
      chk("pulse_requested", {31'b0, outstanding}, 32'd1);
      exp_q.push_back(io.dD_IN);
      chk("one_in_flight", exp_q.size(), 32'd1);
    end
  end

  // Reference model, source side: one outstanding read at a time; busy while
  // outstanding, idle in the result cycle, results in capture order.
  always @(negedge sCLK) begin
    if (in_rst) begin
      if (sRST) chk("rdy_in_reset", {31'b0, io.sRDY}, 32'd0);
      chk("no_valid_in_reset", {31'b0, io.sVALID}, 32'd0);
    end else begin
      if (io.sVALID === 1'b1) begin
        valids++;
        chk("valid_requested", {31'b0, outstanding}, 32'd1);
        chk("rdy_with_valid", {31'b0, io.sRDY}, 32'd1);
        chk("sample_ready", exp_q.size(), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("data", io.sD_OUT, mon_exp);
          if (cnt_chk && have_last) chk("increasing", {31'b0, (io.sD_OUT > last_sd)}, 32'd1);
          last_sd   = io.sD_OUT;
          have_last = 1'b1;
        end
        outstanding = 1'b0;
      end else if (outstanding) begin
        chk("rdy_while_busy", {31'b0, io.sRDY}, 32'd0);
      end
      if (io.sREQ === 1'b1 && io.sRDY === 1'b1) begin
        outstanding = 1'b1;
        accepts++;
      end
    end
  end

  task automatic tick();
    @(posedge sCLK);
    #1;
  endtask

  task automatic wait_rdy(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n && !ok; i++) begin
      if (io.sRDY === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && outstanding; i++) tick();
    chk({tag, "_drained"}, {31'b0, outstanding}, 32'd0);
  endtask

  task automatic read_one(input string tag, input logic [31:0] exp_v, input int maxcyc);
    int p0, v0, cyc;
    bit ok, got;
    p0 = pulses;
    v0 = valids;
    wait_rdy(50, ok);
    chk({tag, "_rdy"}, {31'b0, ok}, 32'd1);
    io.sREQ = 1'b1;
    tick();
    io.sREQ = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge sCLK);
      cyc++;
      if (io.sVALID === 1'b1) got = 1'b1;
    end
    chk({tag, "_valid_seen"}, {31'b0, got}, 32'd1);
    chk({tag, "_latency_ok"}, {31'b0, (cyc <= maxcyc)}, 32'd1);
    chk({tag, "_data"}, io.sD_OUT, exp_v);
    repeat (20) tick();
    chk({tag, "_one_pulse"}, pulses - p0, 32'd1);
    chk({tag, "_one_valid"}, valids - v0, 32'd1);
    chk({tag, "_held"}, io.sD_OUT, exp_v);
  endtask

  task automatic ratio_run(input string tag, input realtime sh, input realtime dh, input int n);
    int a0, p0, v0;
    s_half = sh;
    d_half = dh;
    repeat (4) @(posedge dCLK);
    tick();
    a0 = accepts;
    p0 = pulses;
    v0 = valids;
    dmode = 2;
    for (int i = 0; i < n * 80 && (valids - v0) < n; i++) begin
      io.sREQ = 1'($urandom_range(0, 1));
      tick();
    end
    io.sREQ = 1'b0;
    drain(tag);
    dmode = 0;
    chk({tag, "_count"}, {31'b0, ((valids - v0) >= n)}, 32'd1);
    chk({tag, "_pulses"}, pulses - p0, accepts - a0);
    chk({tag, "_valids"}, valids - v0, accepts - a0);
  endtask

  initial begin
    int  a0, p0, v0, cyc;
    bit  ok, got;
    io.sREQ   = 1'b0;
    io1.sREQ  = 1'b0;
    io1.dD_IN = 1'b0;

    // Reset state
    sRST   = 1'b1;
    in_rst = 1'b1;
    repeat (10) tick();
    chk("rst_sdout", io.sD_OUT, INIT);
    chk("rst_valid", {31'b0, io.sVALID}, 32'd0);
    chk("rst_rdy", {31'b0, io.sRDY}, 32'd0);
    chk("rst_dpulse", {31'b0, io.dPULSE}, 32'd0);
    chk("w1_rst_sdout", {31'b0, io1.sD_OUT}, 32'd1);
    sRST = 1'b0;
    repeat (4) @(posedge dCLK);
    tick();
    in_rst = 1'b0;
    chk("rdy_after_reset", {31'b0, io.sRDY}, 32'd1);

    // Basic read, sCLK 10ns / dCLK 13ns: bound 3 dCLK + 4 sCLK ~ 8 sCLK
    d_fixed = 32'hA5A5_0001;
    repeat (3) @(posedge dCLK);
    tick();
    read_one("basic", 32'hA5A5_0001, 8);

    // Ignored requests: slow dCLK so five pulses fit inside one transaction
    d_half  = 30.0;
    d_fixed = 32'h0000_BEEF;
    repeat (3) @(posedge dCLK);
    tick();
    wait_rdy(50, ok);
    chk("ign_rdy", {31'b0, ok}, 32'd1);
    a0 = accepts;
    p0 = pulses;
    v0 = valids;
    io.sREQ = 1'b1;
    tick();
    io.sREQ = 1'b0;
    repeat (5) begin
      tick();
      io.sREQ = 1'b1;
      tick();
      io.sREQ = 1'b0;
    end
    for (int i = 0; i < 200 && valids == v0; i++) tick();
    repeat (30) tick();
    chk("ign_accepts", accepts - a0, 32'd1);
    chk("ign_pulses", pulses - p0, 32'd1);
    chk("ign_valids", valids - v0, 32'd1);
    chk("ign_data", io.sD_OUT, 32'h0000_BEEF);
    d_half = 6.5;
    repeat (3) @(posedge dCLK);
    tick();

    // Back-to-back with a free-running counter
    a0 = accepts;
    p0 = pulses;
    v0 = valids;
    have_last = 1'b0;
    cnt_chk   = 1'b1;
    dmode     = 1;
    io.sREQ   = 1'b1;
    for (int i = 0; i < 20000 && (valids - v0) < 1000; i++) tick();
    io.sREQ = 1'b0;
    drain("b2b");
    cnt_chk = 1'b0;
    dmode   = 0;
    chk("b2b_count", {31'b0, ((valids - v0) >= 1000)}, 32'd1);
    chk("b2b_pulses", pulses - p0, accepts - a0);
    chk("b2b_valids", valids - v0, accepts - a0);

    // Reset mid-flight, with sREQ held during reset
    d_fixed = 32'h1234_5678;
    repeat (3) @(posedge dCLK);
    tick();
    wait_rdy(50, ok);
    chk("midrst_rdy_before", {31'b0, ok}, 32'd1);
    v0 = valids;
    io.sREQ = 1'b1;
    tick();
    in_rst      = 1'b1;
    outstanding = 1'b0;
    exp_q.delete();
    sRST = 1'b1;
    repeat (4) @(posedge dCLK);
    tick();
    chk("midrst_sdout", io.sD_OUT, INIT);
    io.sREQ = 1'b0;
    sRST    = 1'b0;
    wait_rdy(8, ok);
    chk("midrst_rdy_back", {31'b0, ok}, 32'd1);
    repeat (5) @(posedge dCLK);
    tick();
    in_rst = 1'b0;
    repeat (20) tick();
    chk("midrst_no_valid", valids - v0, 32'd0);
    chk("midrst_sdout_held", io.sD_OUT, INIT);
    read_one("post_rst", 32'h1234_5678, 8);

    // Clock ratios with random data every dCLK and random requests
    ratio_run("fast_d", 10.0, 1.5, 100);
    ratio_run("slow_d", 2.0, 20.0, 100);
    s_half = 5.0;
    d_half = 6.5;
    repeat (4) @(posedge dCLK);
    tick();

    // width=1, init=1 instance: read of dD_IN=0
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (io1.sRDY === 1'b1) ok = 1'b1;
      else tick();
    end
    chk("w1_rdy", {31'b0, ok}, 32'd1);
    io1.sREQ = 1'b1;
    tick();
    io1.sREQ = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge sCLK);
      cyc++;
      if (io1.sVALID === 1'b1) got = 1'b1;
    end
    chk("w1_valid", {31'b0, got}, 32'd1);
    chk("w1_data", {31'b0, io1.sD_OUT}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
